// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master: FSM state encoding and SPI mode pair.
// Latency: none (types only).
// Backpressure: none (types only).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: half-period strobes every div+1 enabled cycles, registered sck level.
// Latency: first half_tick in the (div+1)-th cycle after en rises; sck toggles on the edge ending a tick.
// Backpressure: none; free-running while en is high, cleared and parked at idle_lvl while en is low.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   en          run the divider (low: counter cleared, sck follows idle_lvl)
//   xfer        half-periods toggle sck and produce lead/trail strobes
//   idle_lvl    SCK idle level (CPOL)
//   div         half-period length minus one, must be held stable while en
//   half_tick   last cycle of a half-period
//   lead_tick   half_tick whose edge moves sck away from idle_lvl
//   trail_tick  half_tick whose edge returns sck to idle_lvl
//   sck         registered SPI clock
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 xfer,
  input  logic                 idle_lvl,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 half_tick,
  output logic                 lead_tick,
  output logic                 trail_tick,
  output logic                 sck
);

  logic [DIV_WIDTH-1:0] cnt;

  // Counter restarts at zero on every boundary and only ever compares
  // equal to a stable div, so it can never wrap early into a short half-period.
  assign half_tick  = en && (cnt == div);
  assign lead_tick  = half_tick && xfer && (sck == idle_lvl);
  assign trail_tick = half_tick && xfer && (sck != idle_lvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= idle_lvl;
    end else begin
      if (half_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_WIDTH'(1);
      end
      if (half_tick && xfer) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: programmable divider, CPOL/CPHA modes, variable length, one-hot chip selects.
// Latency: done pulses (2*len+2)*(div+1)+1 cycles after the cycle start is presented in IDLE.
// Backpressure: start is accepted only in IDLE; start while busy is dropped, never queued.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   start       transfer request, sampled only in IDLE
//   cs_sel      chip-select index (out of range: no chip select asserted)
//   len         bits to transfer (0 or > DATA_WIDTH means DATA_WIDTH)
//   div         SCK half-period = div+1 clk cycles
//   cpol, cpha  SPI mode
//   tx_data     right-aligned transmit word, bit len-1 first
//   rx_data     right-aligned, zero-extended receive word, valid with done
//   busy, done  transfer in progress / one-cycle completion pulse
//   sck, sdo, sdi, cs_n   SPI pins
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CS     = 2,
  parameter  int DIV_WIDTH  = 8,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CSW-1:0]        cs_sel,
  input  logic [LW-1:0]         len,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic [NUM_CS-1:0]     cs_n
);

  // Half-period counter must reach 2*DATA_WIDTH-1.
  localparam int HW = LW + 1;

  spi_state_t            state;
  spi_mode_t             mode_q;
  logic [LW-1:0]         len_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [HW-1:0]         hcnt;

  logic                  half_tick;
  logic                  lead_tick;
  logic                  trail_tick;
  logic                  idle_lvl;
  logic                  last_half;
  logic [LW-1:0]         len_eff;
  logic [DATA_WIDTH-1:0] tx_aligned;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      v[i] = (int'(sel) != i);
    end
    return v;
  endfunction

  assign len_eff = ((len == '0) || (len > LW'(DATA_WIDTH))) ? LW'(DATA_WIDTH) : len;

  // Left-justify so the first bit to send is always the MSB of the shifter.
  assign tx_aligned = tx_data << (LW'(DATA_WIDTH) - len_eff);

  assign last_half = (hcnt == ({len_q, 1'b0} - HW'(1)));

  // SCK tracks the live cpol input while idle so the bus parks correctly
  // before the first transfer; once running it uses the latched mode.
  assign idle_lvl = (state == IDLE) ? cpol : mode_q.cpol;

  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (state != IDLE),
    .xfer       (state == XFER),
    .idle_lvl   (idle_lvl),
    .div        (div_q),
    .half_tick  (half_tick),
    .lead_tick  (lead_tick),
    .trail_tick (trail_tick),
    .sck        (sck)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      div_q   <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      hcnt    <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sdo     <= 1'b0;
      cs_n    <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sdo  <= 1'b0;
          cs_n <= '1;
          if (start) begin
            state       <= SETUP;
            busy        <= 1'b1;
            mode_q.cpol <= cpol;
            mode_q.cpha <= cpha;
            len_q       <= len_eff;
            div_q       <= div;
            rx_sh       <= '0;
            hcnt        <= '0;
            cs_n        <= cs_decode(cs_sel);
            // cpha=0 presents the first bit before the first edge;
            // cpha=1 drives it on the first (leading) edge instead.
            if (!cpha) begin
              sdo   <= tx_aligned[DATA_WIDTH-1];
              tx_sh <= tx_aligned << 1;
            end else begin
              tx_sh <= tx_aligned;
            end
          end
        end

        SETUP: begin
          if (half_tick) begin
            state <= XFER;
          end
        end

        XFER: begin
          if (lead_tick) begin
            if (!mode_q.cpha) begin
              rx_sh <= {rx_sh[DATA_WIDTH-2:0], sdi};
            end else begin
              sdo   <= tx_sh[DATA_WIDTH-1];
              tx_sh <= tx_sh << 1;
            end
          end
          if (trail_tick) begin
            if (mode_q.cpha) begin
              rx_sh <= {rx_sh[DATA_WIDTH-2:0], sdi};
            end else if (!last_half) begin
              sdo   <= tx_sh[DATA_WIDTH-1];
              tx_sh <= tx_sh << 1;
            end
          end
          if (half_tick) begin
            hcnt <= hcnt + HW'(1);
            if (last_half) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (half_tick) begin
            state   <= IDLE;
            cs_n    <= '1;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: table of directed transfers plus hand sequences for reset, back-to-back and chip selects.
// Latency: cycle 0 is the cycle in which start is presented; cycle 1 follows the accepting edge.
// Backpressure: an SPI slave model captures sdo on the mode's sample edge and counts rising sck edges.
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cpol, cpha, sdi, sdo, sck, busy, done;
  logic        cs_sel;
  logic [5:0]  len;
  logic [7:0]  div;
  logic [31:0] tx_data, rx_data;
  logic [1:0]  cs_n;
  logic        loop_en, sdi_val;

  assign sdi = loop_en ? sdo : sdi_val;

  logic        start_b;
  logic [1:0]  cs_sel_b;
  logic [31:0] rx_b4, rx_b3;
  logic        busy_b4, busy_b3, done_b4, done_b3, sck_b4, sck_b3, sdo_b4, sdo_b3;
  logic [3:0]  cs_n_b4;
  logic [2:0]  cs_n_b3;

  spi_master_multi #(.DATA_WIDTH(32), .NUM_CS(2), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .len(len), .div(div),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
    .done(done), .sck(sck), .sdo(sdo), .sdi(sdi), .cs_n(cs_n));

  spi_master_multi #(.DATA_WIDTH(32), .NUM_CS(4), .DIV_WIDTH(8)) dut_b4 (
    .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_sel_b), .len(len), .div(div),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .rx_data(rx_b4), .busy(busy_b4),
    .done(done_b4), .sck(sck_b4), .sdo(sdo_b4), .sdi(sdi), .cs_n(cs_n_b4));

  spi_master_multi #(.DATA_WIDTH(32), .NUM_CS(3), .DIV_WIDTH(8)) dut_b3 (
    .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_sel_b), .len(len), .div(div),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .rx_data(rx_b3), .busy(busy_b3),
    .done(done_b3), .sck(sck_b3), .sdo(sdo_b3), .sdi(sdi), .cs_n(cs_n_b3));

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  div;
    logic [5:0]  len;
    logic [31:0] tx;
    logic        cs_sel;
    logic        loop_en;
    logic        sdi_val;
    int          restart_at;
    logic [31:0] exp_rx;
    logic [31:0] exp_cap;
    int          exp_lat;
    int          exp_rises;
    logic [1:0]  exp_cs;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs until done (or budget), acting as slave: samples sdo on the mode's
  // sample edge and counts sck rising edges. Optionally re-asserts start mid-transfer.
  task automatic wait_done(input int restart_at, output int n, output logic [31:0] cap,
                           output int rises);
    logic prev;
    n = 1; cap = '0; rises = 0; prev = sck;
    while (done !== 1'b1 && n < 3000) begin
      start = (n == restart_at);
      if (n == restart_at) begin
        tx_data = 32'hFFFF_0000;
        len     = 6'd4;
      end
      @(posedge clk); #1; n++;
      if (sck !== prev) begin
        if (sck === 1'b1) rises++;
        if ((prev == cpol) == !cpha) cap = {cap[30:0], sdo};
        prev = sck;
      end
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int n, rises;
    logic [31:0] cap;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; div = v.div; len = v.len; tx_data = v.tx;
    cs_sel = v.cs_sel; loop_en = v.loop_en; sdi_val = v.sdi_val;
    @(posedge clk); #1;
    check({tag, ".idle_sck"}, 32'(sck), 32'(v.cpol));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    check({tag, ".cs_n"}, 32'(cs_n), 32'(v.exp_cs));
    check({tag, ".setup_sck"}, 32'(sck), 32'(v.cpol));
    wait_done(v.restart_at, n, cap, rises);
    check({tag, ".latency"}, 32'(n), 32'(v.exp_lat));
    check({tag, ".rx_data"}, rx_data, v.exp_rx);
    check({tag, ".sdo_bits"}, cap, v.exp_cap);
    check({tag, ".sck_rises"}, 32'(rises), 32'(v.exp_rises));
    check({tag, ".cs_n_done"}, 32'(cs_n), 32'h3);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".sdo_done"}, 32'(sdo), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".no_queue"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int n, rises;
    logic [31:0] cap;
    logic saw_done, cs_ok;

    // Latency = (2*len+2)*(div+1)+1.
    //          cpol cpha div   len    tx             sel  loop sdi rst exp_rx         exp_cap        lat  rises cs
    vecs[0] = '{1'b0, 1'b0, 8'd1, 6'd8,  32'h0000_00A5, 1'b0, 1'b1, 1'b0, 0,  32'h0000_00A5, 32'h0000_00A5, 37,  8,  2'b10};
    vecs[1] = '{1'b1, 1'b1, 8'd0, 6'd24, 32'h0012_3456, 1'b0, 1'b0, 1'b1, 0,  32'h00FF_FFFF, 32'h0012_3456, 51,  24, 2'b10};
    vecs[2] = '{1'b0, 1'b1, 8'd2, 6'd16, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0, 0,  32'h0000_BEEF, 32'h0000_BEEF, 103, 16, 2'b10};
    vecs[3] = '{1'b1, 1'b0, 8'd2, 6'd16, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0, 0,  32'h0000_BEEF, 32'h0000_BEEF, 103, 16, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 8'd0, 6'd5,  32'hFFFF_FFF3, 1'b1, 1'b1, 1'b0, 0,  32'h0000_0013, 32'h0000_0013, 13,  5,  2'b01};
    vecs[5] = '{1'b0, 1'b0, 8'd0, 6'd40, 32'h89AB_CDEF, 1'b0, 1'b1, 1'b0, 0,  32'h89AB_CDEF, 32'h89AB_CDEF, 67,  32, 2'b10};
    vecs[6] = '{1'b0, 1'b0, 8'd1, 6'd8,  32'h0000_005A, 1'b0, 1'b1, 1'b0, 10, 32'h0000_005A, 32'h0000_005A, 37,  8,  2'b10};
    vecs[7] = '{1'b0, 1'b0, 8'd0, 6'd0,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 67,  32, 2'b10};

    rst = 1'b1; start = 1'b0; start_b = 1'b0; cpol = 1'b0; cpha = 1'b0;
    div = '0; len = '0; tx_data = '0; cs_sel = 1'b0; cs_sel_b = '0;
    loop_en = 1'b0; sdi_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.rx_data", rx_data, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sdo", 32'(sdo), 32'd0);
    check("reset.cs_n", 32'(cs_n), 32'h3);
    check("reset.sck", 32'(sck), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

    // Reset in the middle of XFER aborts with no done pulse.
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b1; div = 8'd1; len = 6'd8; tx_data = 32'h77;
    cs_sel = 1'b0; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort.cs_n", 32'(cs_n), 32'h3);
    check("abort.sck", 32'(sck), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort.no_done", 32'(saw_done), 32'd0);
    run_row('{1'b0, 1'b0, 8'd1, 6'd8, 32'h3C, 1'b0, 1'b1, 1'b0, 0,
              32'h3C, 32'h3C, 37, 8, 2'b10}, "after_abort");

    // start presented in the done cycle is accepted.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; div = 8'd0; len = 6'd4; tx_data = 32'hA;
    cs_sel = 1'b0; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(0, n, cap, rises);
    check("b2b.first_lat", 32'(n), 32'd11);
    check("b2b.first_rx", rx_data, 32'hA);
    tx_data = 32'h5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.done_low", 32'(done), 32'd0);
    check("b2b.cs_n", 32'(cs_n), 32'h2);
    wait_done(0, n, cap, rises);
    check("b2b.second_lat", 32'(n), 32'd11);
    check("b2b.second_rx", rx_data, 32'h5);

    // cs_sel=3: selects cs_n[3] on a 4-CS master, nothing on a 3-CS master.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; div = 8'd0; len = 6'd4; tx_data = 32'h9;
    loop_en = 1'b0; sdi_val = 1'b1; cs_sel_b = 2'd3; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    check("cs4.cs_n", 32'(cs_n_b4), 32'h7);
    check("cs3.busy", 32'(busy_b3), 32'd1);
    n = 1; cs_ok = 1'b1;
    while (done_b3 !== 1'b1 && n < 200) begin
      if (cs_n_b3 !== 3'b111) cs_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    check("cs3.cs_n_high", 32'(cs_ok), 32'd1);
    check("cs3.latency", 32'(n), 32'd11);
    check("cs4.done", 32'(done_b4), 32'd1);
    check("cs3.rx_data", rx_b3, 32'hF);
    check("cs4.rx_data", rx_b4, 32'hF);
    check("cs4.cs_n_done", 32'(cs_n_b4), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
